// File: rtl/vend_pkg.sv
// Shared definitions for the newspaper vending path: coin codes, emitter states, pricing.
package vend_pkg;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_5    = 2'b01;
    localparam logic [1:0] COIN_10   = 2'b10;

    typedef enum logic [1:0] {
        EM_IDLE = 2'b00,
        EM_SEND = 2'b01,
        EM_GAP  = 2'b10
    } emit_state_e;

    // Pricing used by the downstream vending FSM (rupees).
    localparam int unsigned PRICE_RS  = 15;
    localparam int unsigned CHANGE_RS = 5;

endpackage

// File: rtl/coin_debounce.sv
// Two-flop synchroniser plus level debouncer; pulses qual once per debounced 0->1 flip.
module coin_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sense,
    output logic qual
);

    logic [1:0] sync_q, sync_d;
    logic       stable_q, stable_d;
    logic [3:0] cnt_q, cnt_d;
    logic       qual_q, qual_d;
    logic       synced;

    assign synced = sync_q[1];

    // Count consecutive mismatches against the stable level; flip after DEBOUNCE_CYCLES.
    // The stable level resets high so the sensor must first be seen low (armed) before
    // a coin can qualify; a sensor stuck high across reset never produces a coin.
    always_comb begin
        sync_d   = {sync_q[0], sense};
        stable_d = stable_q;
        cnt_d    = 4'd0;
        qual_d   = 1'b0;
        if (synced != stable_q) begin
            if (cnt_q == 4'(DEBOUNCE_CYCLES - 1)) begin
                stable_d = synced;
                qual_d   = synced;
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= 2'b00;
            stable_q <= 1'b1;
            cnt_q    <= 4'd0;
            qual_q   <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            qual_q   <= qual_d;
        end
    end

    assign qual = qual_q;

endmodule

// File: rtl/coin_acceptor.sv
// Coin front end: debounced sensors -> coin FIFO -> paced single-cycle coin codes.
module coin_acceptor
    import vend_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned FIFO_DEPTH      = 4,
    parameter int unsigned GAP_CYCLES      = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          nickel_sense,
    input  logic                          dime_sense,
    input  logic                          hold,
    output logic [1:0]                    coin,
    output logic                          reject,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    logic            qual_nickel;
    logic            qual_dime;

    logic [FIFO_DEPTH-1:0] mem_q, mem_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    emit_state_e     state_q, state_d;
    logic [2:0]      gap_q, gap_d;
    logic [1:0]      coin_q, coin_d;
    logic            reject_q, reject_d;
    logic            pop;
    logic            push;
    logic            push_bit;

    coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_nickel (
        .clk   (clk),
        .rst_n (reset),
        .sense (nickel_sense),
        .qual  (qual_nickel)
    );

    coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dime (
        .clk   (clk),
        .rst_n (reset),
        .sense (dime_sense),
        .qual  (qual_dime)
    );

    // Accept decision: pop is evaluated first so a full FIFO can still take a coin.
    always_comb begin
        pop      = (state_q == EM_IDLE) && (count_q != '0) && !hold;
        push     = 1'b0;
        push_bit = qual_dime;
        reject_d = 1'b0;
        if (qual_nickel && qual_dime) begin
            reject_d = 1'b1;
        end else if (qual_nickel || qual_dime) begin
            if ((count_q < CW'(FIFO_DEPTH)) || pop) begin
                push = 1'b1;
            end else begin
                reject_d = 1'b1;
            end
        end
    end

    // FIFO storage, one bit per coin (1 = Rs10), pointers wrap naturally.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_bit;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Emitter: one SEND cycle, GAP_CYCLES idle cycles, then back to IDLE for the next pop.
    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        coin_d  = COIN_NONE;
        case (state_q)
            EM_IDLE: begin
                if (pop) begin
                    coin_d  = mem_q[rd_ptr_q] ? COIN_10 : COIN_5;
                    state_d = EM_SEND;
                end
            end
            EM_SEND: begin
                gap_d   = 3'(GAP_CYCLES - 1);
                state_d = EM_GAP;
            end
            EM_GAP: begin
                if (gap_q == 3'd0) begin
                    state_d = EM_IDLE;
                end else begin
                    gap_d = gap_q - 3'd1;
                end
            end
            default: state_d = EM_IDLE;
        endcase
    end

    // State registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= EM_IDLE;
            gap_q    <= 3'd0;
            coin_q   <= COIN_NONE;
            reject_q <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
            gap_q    <= gap_d;
            coin_q   <= coin_d;
            reject_q <= reject_d;
        end
    end

    assign coin       = coin_q;
    assign reject     = reject_q;
    assign fifo_count = count_q;
    assign busy       = (count_q != '0) || (state_q != EM_IDLE);

endmodule

// File: tb/tb_coin_acceptor.sv
// Bench for coin_acceptor: directed scenarios plus random sensor/hold traffic vs a reference model.
module tb_coin_acceptor;

    localparam int unsigned D     = 4;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned GAP   = 1;
    localparam logic [15:0] M_MASK = 16'((1 << D) - 1);

    logic       clk;
    logic       reset;
    logic       nickel_sense;
    logic       dime_sense;
    logic       hold;
    logic [1:0] coin;
    logic       reject;
    logic       busy;
    logic [2:0] fifo_count;

    coin_acceptor #(
        .DEBOUNCE_CYCLES (D),
        .FIFO_DEPTH      (DEPTH),
        .GAP_CYCLES      (GAP)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .nickel_sense (nickel_sense),
        .dime_sense   (dime_sense),
        .hold         (hold),
        .coin         (coin),
        .reject       (reject),
        .busy         (busy),
        .fifo_count   (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model (window/queue/timestamp based) ----------------
    bit [15:0]   hist[2];
    int unsigned nval[2];
    bit          stab[2];
    bit          mqual[2];
    bit          p0[2];
    bit          p1[2];
    bit          mq[$];
    int unsigned e_cnt;
    int unsigned next_ok;
    logic [1:0]  x_coin;
    bit          x_rej;
    int unsigned x_cnt;
    bit          x_busy;

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            hist[s] = '0; nval[s] = 0; stab[s] = 1'b1; mqual[s] = 1'b0;
            p0[s] = 1'b0; p1[s] = 1'b0;
        end
        mq.delete();
        e_cnt = 0; next_ok = 0;
        x_coin = 2'b00; x_rej = 1'b0; x_cnt = 0; x_busy = 1'b0;
    endtask

    task automatic model_step();
        bit syn[2];
        bit newq[2];
        bit pop;
        if (!reset) begin
            model_reset();
            return;
        end
        for (int s = 0; s < 2; s++) begin
            syn[s] = p1[s];
            p1[s]  = p0[s];
        end
        p0[0] = nickel_sense;
        p0[1] = dime_sense;
        // emission: at most one coin per GAP+2 edges, only when not held
        pop = (e_cnt >= next_ok) && (mq.size() > 0) && !hold;
        x_coin = 2'b00;
        x_rej  = 1'b0;
        if (pop) begin
            x_coin  = mq.pop_front() ? 2'b10 : 2'b01;
            next_ok = e_cnt + GAP + 2;
        end
        if (mqual[0] && mqual[1]) x_rej = 1'b1;
        else if (mqual[0] || mqual[1]) begin
            if (mq.size() < DEPTH) mq.push_back(mqual[1]);
            else x_rej = 1'b1;
        end
        // stable level flips when the last D synced samples all disagree with it
        for (int s = 0; s < 2; s++) begin
            hist[s] = {hist[s][14:0], syn[s]};
            if (nval[s] < 16) nval[s]++;
            newq[s] = 1'b0;
            if (nval[s] >= D && ((hist[s] ^ {16{stab[s]}}) & M_MASK) == M_MASK) begin
                stab[s] = ~stab[s];
                newq[s] = stab[s];
            end
            mqual[s] = newq[s];
        end
        x_cnt  = mq.size();
        x_busy = (mq.size() != 0) || (e_cnt + 1 < next_ok);
        e_cnt++;
    endtask

    // ---------------- observation ----------------
    int         tick_no = 0;
    int         first_coin_tick;
    int         last_coin_tick;
    int         min_sp;
    int         obs_rej;
    logic [1:0] obs_seq[$];

    task automatic clear_obs();
        first_coin_tick = -1;
        last_coin_tick  = -1;
        min_sp          = 1000;
        obs_rej         = 0;
        obs_seq.delete();
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_eq("coin", 32'(coin), 32'(x_coin));
        check_eq("reject", 32'(reject), 32'(x_rej));
        check_eq("fifo_count", 32'(fifo_count), x_cnt);
        check_eq("busy", 32'(busy), 32'(x_busy));
        if (coin != 2'b00) begin
            if (first_coin_tick < 0) first_coin_tick = tick_no;
            if (last_coin_tick >= 0 && (tick_no - last_coin_tick) < min_sp)
                min_sp = tick_no - last_coin_tick;
            last_coin_tick = tick_no;
            obs_seq.push_back(coin);
        end
        if (reject) obs_rej++;
        tick_no++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse(input bit is_dime, input int hi, input int lo);
        if (is_dime) dime_sense = 1'b1; else nickel_sense = 1'b1;
        run(hi);
        dime_sense = 1'b0; nickel_sense = 1'b0;
        run(lo);
    endtask

    logic [1:0] exp3[4];
    int         t0;
    bit         got_coin;

    initial begin
        reset = 1'b0; nickel_sense = 1'b0; dime_sense = 1'b0; hold = 1'b0;
        model_reset();
        clear_obs();
        run(3);
        check_eq("reset_coin", 32'(coin), 32'd0);
        check_eq("reset_busy", 32'(busy), 32'd0);
        check_eq("reset_count", 32'(fifo_count), 32'd0);
        reset = 1'b1;
        run(10);

        // single nickel: coin 7 edges after the first sampled high
        clear_obs();
        t0 = tick_no;
        pulse(1'b0, 10, 20);
        check_eq("t1_coins", 32'(obs_seq.size()), 32'd1);
        check_eq("t1_code", 32'(obs_seq.size() > 0 ? obs_seq[0] : 2'b11), 32'd1);
        check_eq("t1_latency", 32'(first_coin_tick - t0), 32'(D + 3));
        check_eq("t1_reject", 32'(obs_rej), 32'd0);
        check_eq("t1_busy", 32'(busy), 32'd0);

        // bounce on dime sensor
        clear_obs();
        foreach (exp3[i]) exp3[i] = 2'b00;
        begin
            bit pat[9] = '{1, 0, 1, 1, 0, 1, 1, 1, 1};
            for (int i = 0; i < 9; i++) begin
                dime_sense = pat[i];
                tick();
            end
        end
        run(8);
        dime_sense = 1'b0;
        run(20);
        check_eq("t2_coins", 32'(obs_seq.size()), 32'd1);
        check_eq("t2_code", 32'(obs_seq.size() > 0 ? obs_seq[0] : 2'b11), 32'd2);

        // burst order held in FIFO, then released
        clear_obs();
        hold = 1'b1;
        pulse(1'b1, 6, 8);
        pulse(1'b0, 6, 8);
        pulse(1'b1, 6, 8);
        pulse(1'b0, 6, 8);
        check_eq("t3_count", 32'(fifo_count), 32'd4);
        check_eq("t3_held", 32'(obs_seq.size()), 32'd0);
        hold = 1'b0;
        run(30);
        exp3 = '{2'b10, 2'b01, 2'b10, 2'b01};
        check_eq("t3_coins", 32'(obs_seq.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            check_eq("t3_order", 32'((i < obs_seq.size()) ? obs_seq[i] : 2'b11), 32'(exp3[i]));
        check_eq("t3_spacing_ok", 32'(min_sp >= int'(GAP + 2)), 32'd1);

        // overflow: fifth coin rejected
        clear_obs();
        hold = 1'b1;
        for (int i = 0; i < 5; i++) pulse(1'b0, 6, 8);
        check_eq("t4_count", 32'(fifo_count), 32'd4);
        check_eq("t4_rejects", 32'(obs_rej), 32'd1);
        hold = 1'b0;
        run(30);
        check_eq("t4_coins", 32'(obs_seq.size()), 32'd4);

        // simultaneous qualify
        clear_obs();
        nickel_sense = 1'b1; dime_sense = 1'b1;
        run(8);
        nickel_sense = 1'b0; dime_sense = 1'b0;
        run(20);
        check_eq("t5_rejects", 32'(obs_rej), 32'd1);
        check_eq("t5_coins", 32'(obs_seq.size()), 32'd0);
        check_eq("t5_count", 32'(fifo_count), 32'd0);

        // reset during SEND
        clear_obs();
        hold = 1'b1;
        pulse(1'b1, 6, 8);
        pulse(1'b0, 6, 8);
        pulse(1'b0, 6, 8);
        hold = 1'b0;
        got_coin = 1'b0;
        for (int i = 0; i < 20 && !got_coin; i++) begin
            tick();
            if (coin != 2'b00) got_coin = 1'b1;
        end
        check_eq("t6_wait_coin", 32'(got_coin), 32'd1);
        check_eq("t6_first_code", 32'(coin), 32'd2);
        check_eq("t6_queued", 32'(fifo_count), 32'd2);
        #2;
        reset = 1'b0;
        #1;
        check_eq("t6_async_coin", 32'(coin), 32'd0);
        check_eq("t6_async_count", 32'(fifo_count), 32'd0);
        check_eq("t6_async_busy", 32'(busy), 32'd0);
        run(3);
        reset = 1'b1;
        clear_obs();
        run(40);
        check_eq("t6_after_coins", 32'(obs_seq.size()), 32'd0);

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 5) == 0) nickel_sense = ~nickel_sense;
            if ($urandom_range(0, 5) == 0) dime_sense = ~dime_sense;
            if ($urandom_range(0, 24) == 0) hold = ~hold;
            if (i == 700) reset = 1'b0;
            if (i == 703) reset = 1'b1;
            tick();
        end
        nickel_sense = 1'b0; dime_sense = 1'b0; hold = 1'b0;
        run(40);
        check_eq("final_idle", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
